// File: rtl/bomb_timer.sv
`default_nettype none
// ============================================================================
// Module   : bomb_timer
// Purpose  : Owns every live bomb on the 10x10 arena. Accepts drop requests
//            from both players, ages each bomb NEW -> AGED -> EXPLODE, paints
//            plus-shaped blasts clipped by the grid edge and by walls, and
//            flags players standing in a blast. Cell index = row*10 + col.
// Ports    : pixel_clk    - sole clock
//            rst_n        - asynchronous reset, active-low
//            p1_drop/p2_drop - one-cycle drop requests
//            p1_pos/p2_pos   - player cell index (drop target and hit probe)
//            Arena_bit0   - 1 = wall cell, blocks blast propagation
//            Bomb_bit1/0  - per-cell bomb code {MSB,LSB}: 00 empty, 01 NEW,
//                           10 AGED, 11 EXPLODE
//            p1/p2_drop_ack - one-cycle pulse when a drop is accepted
//            p1/p2_hit    - player cell is exploding
//            active_cnt   - number of non-idle bomb slots
// Revision : 1.0 - initial release
// ============================================================================
module bomb_timer #(
  parameter int N_SLOTS      = 4,
  parameter int PHASE_CYCLES = 25_000_000,
  parameter int BLAST_CYCLES = 12_500_000,
  parameter int RANGE        = 1
) (
  input  logic         pixel_clk,
  input  logic         rst_n,
  input  logic         p1_drop,
  input  logic [6:0]   p1_pos,
  input  logic         p2_drop,
  input  logic [6:0]   p2_pos,
  input  logic [99:0]  Arena_bit0,
  output logic [99:0]  Bomb_bit0,
  output logic [99:0]  Bomb_bit1,
  output logic         p1_drop_ack,
  output logic         p2_drop_ack,
  output logic         p1_hit,
  output logic         p2_hit,
  output logic [3:0]   active_cnt
);

  localparam int MAX_CYC = (PHASE_CYCLES > BLAST_CYCLES) ? PHASE_CYCLES : BLAST_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int SW      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  localparam logic [CW-1:0] PHASE_LOAD = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] BLAST_LOAD = CW'(BLAST_CYCLES - 1);
  localparam logic [6:0]    LAST_CELL  = 7'd99;

  // State encoding doubles as the cell code painted into the bomb map.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    NEW     = 2'b01,
    AGED    = 2'b10,
    EXPLODE = 2'b11
  } slot_state_t;

  slot_state_t     slot_state [N_SLOTS];
  logic [6:0]      slot_cell  [N_SLOTS];
  logic [CW-1:0]   slot_cnt   [N_SLOTS];

  // --------------------------------------------------------------------------
  // Blast arms for a bomb at idx: up/down/left/right out to RANGE cells.
  // Each arm stops at the grid edge (no row wrap) or at the first wall, and
  // the wall cell itself is left unpainted.
  // --------------------------------------------------------------------------
  function automatic logic [99:0] blast_mask(input logic [6:0] idx,
                                             input logic [99:0] walls);
    logic [99:0] m;
    logic [6:0]  ci;
    int          row, col, r, c;
    logic        up_ok, dn_ok, lf_ok, rt_ok;
    m     = '0;
    row   = int'(idx) / 10;
    col   = int'(idx) % 10;
    up_ok = 1'b1;
    dn_ok = 1'b1;
    lf_ok = 1'b1;
    rt_ok = 1'b1;
    for (int k = 1; k <= RANGE; k++) begin
      r = row - k;
      if (up_ok && r >= 0) begin
        ci = 7'(r * 10 + col);
        if (walls[ci]) up_ok = 1'b0;
        else           m[ci] = 1'b1;
      end else begin
        up_ok = 1'b0;
      end
      r = row + k;
      if (dn_ok && r <= 9) begin
        ci = 7'(r * 10 + col);
        if (walls[ci]) dn_ok = 1'b0;
        else           m[ci] = 1'b1;
      end else begin
        dn_ok = 1'b0;
      end
      c = col - k;
      if (lf_ok && c >= 0) begin
        ci = 7'(row * 10 + c);
        if (walls[ci]) lf_ok = 1'b0;
        else           m[ci] = 1'b1;
      end else begin
        lf_ok = 1'b0;
      end
      c = col + k;
      if (rt_ok && c <= 9) begin
        ci = 7'(row * 10 + c);
        if (walls[ci]) rt_ok = 1'b0;
        else           m[ci] = 1'b1;
      end else begin
        rt_ok = 1'b0;
      end
    end
    return m;
  endfunction

  // --------------------------------------------------------------------------
  // Drop arbitration. Player 1 is served first; player 2 gets the lowest idle
  // slot that player 1 did not take, and loses if both target the same cell.
  // --------------------------------------------------------------------------
  logic          p1_busy, p2_busy;
  logic          p1_free, p2_free;
  logic [SW-1:0] p1_slot, p2_slot;
  logic          p1_ok, p2_ok;

  always_comb begin
    p1_busy = 1'b0;
    p2_busy = 1'b0;
    p1_free = 1'b0;
    p2_free = 1'b0;
    p1_slot = '0;
    p2_slot = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      if (slot_state[s] != IDLE) begin
        if (slot_cell[s] == p1_pos) p1_busy = 1'b1;
        if (slot_cell[s] == p2_pos) p2_busy = 1'b1;
      end
    end
    // Descending scan so the lowest-index idle slot is the one left standing.
    for (int s = N_SLOTS - 1; s >= 0; s--) begin
      if (slot_state[s] == IDLE) begin
        p1_free = 1'b1;
        p1_slot = SW'(s);
      end
    end
    p1_ok = p1_drop && (p1_pos <= LAST_CELL) && !p1_busy && p1_free;
    for (int s = N_SLOTS - 1; s >= 0; s--) begin
      if (slot_state[s] == IDLE && !(p1_ok && SW'(s) == p1_slot)) begin
        p2_free = 1'b1;
        p2_slot = SW'(s);
      end
    end
    p2_ok = p2_drop && (p2_pos <= LAST_CELL) && !p2_busy && p2_free &&
            !(p1_ok && p2_pos == p1_pos);
  end

  // Number of slots that will be live after this edge, so active_cnt moves in
  // step with the slot state rather than a cycle behind it.
  logic [3:0] live_next;

  always_comb begin
    live_next = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      if ((slot_state[s] != IDLE && !(slot_state[s] == EXPLODE && slot_cnt[s] == '0)) ||
          (p1_ok && p1_slot == SW'(s)) ||
          (p2_ok && p2_slot == SW'(s))) begin
        live_next = live_next + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Map build: one mask per code, merged so the highest code wins per cell.
  // --------------------------------------------------------------------------
  logic [99:0] new_m, aged_m, expl_m;

  always_comb begin
    new_m  = '0;
    aged_m = '0;
    expl_m = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      case (slot_state[s])
        NEW:     new_m[slot_cell[s]]  = 1'b1;
        AGED:    aged_m[slot_cell[s]] = 1'b1;
        EXPLODE: begin
          expl_m[slot_cell[s]] = 1'b1;
          expl_m = expl_m | blast_mask(slot_cell[s], Arena_bit0);
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Slot FSMs, bomb map, acks, hits and live count.
  // --------------------------------------------------------------------------
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        slot_state[s] <= IDLE;
        slot_cell[s]  <= '0;
        slot_cnt[s]   <= '0;
      end
      Bomb_bit0   <= '0;
      Bomb_bit1   <= '0;
      p1_drop_ack <= 1'b0;
      p2_drop_ack <= 1'b0;
      p1_hit      <= 1'b0;
      p2_hit      <= 1'b0;
      active_cnt  <= '0;
    end else begin
      for (int s = 0; s < N_SLOTS; s++) begin
        case (slot_state[s])
          IDLE: begin
            if (p1_ok && p1_slot == SW'(s)) begin
              slot_state[s] <= NEW;
              slot_cell[s]  <= p1_pos;
              slot_cnt[s]   <= PHASE_LOAD;
            end else if (p2_ok && p2_slot == SW'(s)) begin
              slot_state[s] <= NEW;
              slot_cell[s]  <= p2_pos;
              slot_cnt[s]   <= PHASE_LOAD;
            end
          end
          NEW, AGED: begin
            // A neighbouring blast covering this bomb sets it off at once.
            if (Bomb_bit1[slot_cell[s]] && Bomb_bit0[slot_cell[s]]) begin
              slot_state[s] <= EXPLODE;
              slot_cnt[s]   <= BLAST_LOAD;
            end else if (slot_cnt[s] == '0) begin
              slot_state[s] <= (slot_state[s] == NEW) ? AGED : EXPLODE;
              slot_cnt[s]   <= (slot_state[s] == NEW) ? PHASE_LOAD : BLAST_LOAD;
            end else begin
              slot_cnt[s] <= slot_cnt[s] - CW'(1);
            end
          end
          EXPLODE: begin
            if (slot_cnt[s] == '0) slot_state[s] <= IDLE;
            else                   slot_cnt[s]   <= slot_cnt[s] - CW'(1);
          end
          default: slot_state[s] <= IDLE;
        endcase
      end

      Bomb_bit1   <= expl_m | aged_m;
      Bomb_bit0   <= expl_m | (new_m & ~aged_m);
      p1_drop_ack <= p1_ok;
      p2_drop_ack <= p2_ok;
      p1_hit      <= (p1_pos <= LAST_CELL) && Bomb_bit1[p1_pos] && Bomb_bit0[p1_pos];
      p2_hit      <= (p2_pos <= LAST_CELL) && Bomb_bit1[p2_pos] && Bomb_bit0[p2_pos];
      active_cnt  <= live_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bomb_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bomb_timer
// Purpose  : Directed self-checking bench for bomb_timer with short timing
//            (PHASE_CYCLES=4, BLAST_CYCLES=2, RANGE=1). "After edge k" means
//            sampled 1 time unit after the k-th rising edge following a drop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bomb_timer;

  logic         pixel_clk = 1'b0;
  logic         rst_n     = 1'b0;
  logic         p1_drop   = 1'b0;
  logic [6:0]   p1_pos    = '0;
  logic         p2_drop   = 1'b0;
  logic [6:0]   p2_pos    = '0;
  logic [99:0]  Arena_bit0 = '0;
  logic [99:0]  Bomb_bit0, Bomb_bit1;
  logic         p1_drop_ack, p2_drop_ack, p1_hit, p2_hit;
  logic [3:0]   active_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 pixel_clk = ~pixel_clk;

  bomb_timer #(
    .N_SLOTS      (4),
    .PHASE_CYCLES (4),
    .BLAST_CYCLES (2),
    .RANGE        (1)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .p1_drop     (p1_drop),
    .p1_pos      (p1_pos),
    .p2_drop     (p2_drop),
    .p2_pos      (p2_pos),
    .Arena_bit0  (Arena_bit0),
    .Bomb_bit0   (Bomb_bit0),
    .Bomb_bit1   (Bomb_bit1),
    .p1_drop_ack (p1_drop_ack),
    .p2_drop_ack (p2_drop_ack),
    .p1_hit      (p1_hit),
    .p2_hit      (p2_hit),
    .active_cnt  (active_cnt)
  );

  task automatic tick;
    @(posedge pixel_clk);
    #1;
  endtask

  function automatic logic [1:0] code_at(input logic [6:0] i);
    return {Bomb_bit1[i], Bomb_bit0[i]};
  endfunction

  task automatic apply_reset;
    p1_drop    = 1'b0;
    p2_drop    = 1'b0;
    Arena_bit0 = '0;
    rst_n      = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    p1_drop = 1'b0;
    p2_drop = 1'b0;
    rst_n   = 1'b0;
    tick;
    total_cnt++;
    if ((Bomb_bit0 | Bomb_bit1) !== '0) $display("FAIL reset_map: got %h/%h want 0", Bomb_bit1, Bomb_bit0);
    else pass_cnt++;
    total_cnt++;
    if ({p1_drop_ack, p2_drop_ack, p1_hit, p2_hit} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {p1_drop_ack, p2_drop_ack, p1_hit, p2_hit});
    else pass_cnt++;
    total_cnt++;
    if (active_cnt !== 4'd0) $display("FAIL reset_active: got %0d want 0", active_cnt);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_life;
    logic [1:0] exp55;
    logic       exp_hit;
    logic [3:0] exp_act;
    apply_reset;
    p1_pos  = 7'd55;
    p2_pos  = 7'd56;
    p1_drop = 1'b1;
    tick;  // edge 0
    p1_drop = 1'b0;
    total_cnt++;
    if (p1_drop_ack !== 1'b1) $display("FAIL life_ack: got %b want 1", p1_drop_ack);
    else pass_cnt++;
    total_cnt++;
    if (active_cnt !== 4'd1) $display("FAIL life_active0: got %0d want 1", active_cnt);
    else pass_cnt++;
    total_cnt++;
    if (code_at(7'd55) !== 2'b00) $display("FAIL life_map_lag: got %b want 00", code_at(7'd55));
    else pass_cnt++;
    for (int c = 1; c <= 12; c++) begin
      tick;
      exp55   = (c <= 4) ? 2'b01 : (c <= 8) ? 2'b10 : (c <= 10) ? 2'b11 : 2'b00;
      exp_hit = (c == 10 || c == 11);
      exp_act = (c <= 9) ? 4'd1 : 4'd0;
      total_cnt++;
      if (code_at(7'd55) !== exp55) $display("FAIL life_map55 edge %0d: got %b want %b", c, code_at(7'd55), exp55);
      else pass_cnt++;
      total_cnt++;
      if (p2_hit !== exp_hit || p1_hit !== exp_hit) $display("FAIL life_hit edge %0d: got p1=%b p2=%b want %b", c, p1_hit, p2_hit, exp_hit);
      else pass_cnt++;
      total_cnt++;
      if (active_cnt !== exp_act) $display("FAIL life_active edge %0d: got %0d want %0d", c, active_cnt, exp_act);
      else pass_cnt++;
      if (c == 1) begin
        total_cnt++;
        if (p1_drop_ack !== 1'b0) $display("FAIL life_ack_pulse: got %b want 0", p1_drop_ack);
        else pass_cnt++;
      end
      if (c == 9) begin
        total_cnt++;
        if ({code_at(7'd45), code_at(7'd65), code_at(7'd54), code_at(7'd56)} !== 8'hFF)
          $display("FAIL life_arms: got %b %b %b %b want 11 each", code_at(7'd45), code_at(7'd65), code_at(7'd54), code_at(7'd56));
        else pass_cnt++;
        total_cnt++;
        if (code_at(7'd66) !== 2'b00 || code_at(7'd35) !== 2'b00) $display("FAIL life_range: got 66=%b 35=%b want 00", code_at(7'd66), code_at(7'd35));
        else pass_cnt++;
      end
      if (c == 11) begin
        total_cnt++;
        if ((Bomb_bit0 | Bomb_bit1) !== '0) $display("FAIL life_clear: got %h/%h want 0", Bomb_bit1, Bomb_bit0);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_walls;
    apply_reset;
    Arena_bit0[19] = 1'b1;
    p1_pos  = 7'd9;
    p2_pos  = 7'd59;
    p1_drop = 1'b1;
    p2_drop = 1'b1;
    tick;  // edge 0
    p1_drop = 1'b0;
    p2_drop = 1'b0;
    repeat (9) tick;  // edge 9: blast visible
    total_cnt++;
    if (code_at(7'd9) !== 2'b11 || code_at(7'd8) !== 2'b11) $display("FAIL wall_paint: got 9=%b 8=%b want 11", code_at(7'd9), code_at(7'd8));
    else pass_cnt++;
    total_cnt++;
    if (code_at(7'd19) !== 2'b00) $display("FAIL wall_block: got 19=%b want 00", code_at(7'd19));
    else pass_cnt++;
    total_cnt++;
    if (code_at(7'd10) !== 2'b00 || code_at(7'd60) !== 2'b00) $display("FAIL wall_nowrap: got 10=%b 60=%b want 00", code_at(7'd10), code_at(7'd60));
    else pass_cnt++;
    total_cnt++;
    if ({code_at(7'd49), code_at(7'd69), code_at(7'd58)} !== 6'h3F) $display("FAIL wall_arms59: got %b %b %b want 11", code_at(7'd49), code_at(7'd69), code_at(7'd58));
    else pass_cnt++;
    repeat (3) tick;
    Arena_bit0 = '0;
  endtask

  task automatic test_arbitration;
    apply_reset;
    p1_pos  = 7'd33;
    p2_pos  = 7'd33;
    p1_drop = 1'b1;
    p2_drop = 1'b1;
    tick;
    p1_drop = 1'b0;
    total_cnt++;
    if (p1_drop_ack !== 1'b1 || p2_drop_ack !== 1'b0) $display("FAIL arb_same_cell: got p1=%b p2=%b want 1 0", p1_drop_ack, p2_drop_ack);
    else pass_cnt++;
    total_cnt++;
    if (active_cnt !== 4'd1) $display("FAIL arb_active: got %0d want 1", active_cnt);
    else pass_cnt++;
    // p2 retries an occupied cell, p1 tries an off-grid index
    p1_pos  = 7'd100;
    p1_drop = 1'b1;
    tick;
    total_cnt++;
    if (p1_drop_ack !== 1'b0 || p2_drop_ack !== 1'b0) $display("FAIL arb_reject: got p1=%b p2=%b want 0 0", p1_drop_ack, p2_drop_ack);
    else pass_cnt++;
    p1_drop = 1'b0;
    p2_pos  = 7'd34;
    tick;
    p2_drop = 1'b0;
    total_cnt++;
    if (p2_drop_ack !== 1'b1 || active_cnt !== 4'd2) $display("FAIL arb_p2_ok: got ack=%b active=%0d want 1 2", p2_drop_ack, active_cnt);
    else pass_cnt++;
  endtask

  task automatic test_full;
    apply_reset;
    p1_pos = 7'd11; p2_pos = 7'd33; p1_drop = 1'b1; p2_drop = 1'b1;
    tick;  // edge 0
    total_cnt++;
    if (p1_drop_ack !== 1'b1 || p2_drop_ack !== 1'b1 || active_cnt !== 4'd2) $display("FAIL full_pair0: got %b %b %0d want 1 1 2", p1_drop_ack, p2_drop_ack, active_cnt);
    else pass_cnt++;
    p1_pos = 7'd66; p2_pos = 7'd88;
    tick;  // edge 1
    total_cnt++;
    if (p1_drop_ack !== 1'b1 || p2_drop_ack !== 1'b1 || active_cnt !== 4'd4) $display("FAIL full_pair1: got %b %b %0d want 1 1 4", p1_drop_ack, p2_drop_ack, active_cnt);
    else pass_cnt++;
    p1_pos = 7'd50; p2_pos = 7'd77;
    tick;  // edge 2: no slot left
    p1_drop = 1'b0; p2_drop = 1'b0;
    total_cnt++;
    if (p1_drop_ack !== 1'b0 || p2_drop_ack !== 1'b0 || active_cnt !== 4'd4) $display("FAIL full_reject: got %b %b %0d want 0 0 4", p1_drop_ack, p2_drop_ack, active_cnt);
    else pass_cnt++;
    repeat (8) tick;  // edge 10: first pair back to idle
    total_cnt++;
    if (active_cnt !== 4'd2) $display("FAIL full_drain: got %0d want 2", active_cnt);
    else pass_cnt++;
    p1_drop = 1'b1;
    tick;  // edge 11: retry lands, second pair retires
    p1_drop = 1'b0;
    total_cnt++;
    if (p1_drop_ack !== 1'b1 || active_cnt !== 4'd1) $display("FAIL full_retry: got ack=%b active=%0d want 1 1", p1_drop_ack, active_cnt);
    else pass_cnt++;
  endtask

  // A at 44 on edge 0, B at 45 on edge 4. Left alone B would still be AGED
  // when A's blast lands, so an EXPLODE code on 45/46 after edge 11 can only
  // come from the chain.
  task automatic test_chain;
    apply_reset;
    p1_pos  = 7'd44;
    p1_drop = 1'b1;
    tick;  // edge 0
    p1_drop = 1'b0;
    repeat (3) tick;
    p2_pos  = 7'd45;
    p2_drop = 1'b1;
    tick;  // edge 4
    p2_drop = 1'b0;
    total_cnt++;
    if (p2_drop_ack !== 1'b1 || active_cnt !== 4'd2) $display("FAIL chain_drop: got ack=%b active=%0d want 1 2", p2_drop_ack, active_cnt);
    else pass_cnt++;
    for (int c = 5; c <= 13; c++) begin
      tick;
      if (c == 8) begin
        total_cnt++;
        if (code_at(7'd45) !== 2'b01 || code_at(7'd44) !== 2'b10) $display("FAIL chain_pre: got 45=%b 44=%b want 01 10", code_at(7'd45), code_at(7'd44));
        else pass_cnt++;
      end
      if (c == 10) begin
        total_cnt++;
        if (active_cnt !== 4'd1) $display("FAIL chain_active10: got %0d want 1", active_cnt);
        else pass_cnt++;
      end
      if (c == 11) begin
        total_cnt++;
        if (code_at(7'd45) !== 2'b11 || code_at(7'd46) !== 2'b11) $display("FAIL chain_fire: got 45=%b 46=%b want 11 11", code_at(7'd45), code_at(7'd46));
        else pass_cnt++;
      end
      if (c == 12) begin
        total_cnt++;
        if (code_at(7'd46) !== 2'b11 || active_cnt !== 4'd0) $display("FAIL chain_end: got 46=%b active=%0d want 11 0", code_at(7'd46), active_cnt);
        else pass_cnt++;
      end
      if (c == 13) begin
        total_cnt++;
        if ((Bomb_bit0 | Bomb_bit1) !== '0) $display("FAIL chain_clear: got %h/%h want 0", Bomb_bit1, Bomb_bit0);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    p1_pos  = 7'd55;
    p1_drop = 1'b1;
    tick;  // edge 0
    p1_drop = 1'b0;
    repeat (6) tick;  // edge 6: map shows AGED
    total_cnt++;
    if (code_at(7'd55) !== 2'b10) $display("FAIL rstmid_aged: got %b want 10", code_at(7'd55));
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;  // well before the next rising edge
    total_cnt++;
    if ((Bomb_bit0 | Bomb_bit1) !== '0 || active_cnt !== 4'd0) $display("FAIL rstmid_async: got map=%h active=%0d want 0 0", Bomb_bit1 | Bomb_bit0, active_cnt);
    else pass_cnt++;
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick;
      total_cnt++;
      if ((Bomb_bit0 | Bomb_bit1) !== '0 || active_cnt !== 4'd0) $display("FAIL rstmid_residual cycle %0d: got map=%h active=%0d want 0 0", c, Bomb_bit1 | Bomb_bit0, active_cnt);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_single_life;
    test_walls;
    test_arbitration;
    test_full;
    test_chain;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
